ysyx_25020037_wbu: RTL and testbench
====================================

// Module: ysyx_25020037_wbu
// PURPOSE
//  Write-back stage directly downstream of the LSU. Accepts one retiring instruction per
//  lsu_valid/wbu_ready handshake. Aligns and sign/zero-extends raw load data, writes the
//  register file and signals commit to the IFU. Converts LSU access faults into trap requests.
//  Keeps the 64-bit minstret counter.
// PARAMETERS
//  RST_PC_MTVAL  32'h0  mtval value driven when no trap is pending
// PORTS
//  clk           in   1   core clock; all state updates on posedge
//  rst_n         in   1   asynchronous, active-low reset
//  lsu_valid     in   1   LSU result valid
//  wbu_ready     out  1   WBU can accept a result
//  lu_to_wu_bus  in   64  {result_or_addr[31:0], rdata[31:0]}
//  du_to_wu_bus  in   44  {pc[31:0], is_store, is_load, load_uns, rop[2:0], rf_we, rd[4:0]}
//  access_fault  in   1   bus error for the instruction being handed over (qualified by lsu_valid)
//  rf_we         out  1   register-file write strobe, 1-cycle pulse
//  rf_waddr      out  5   write index
//  rf_wdata      out  32  write data
//  wbu_valid     out  1   commit pulse to IFU (next fetch may start)
//  commit_pc     out  32  pc of committing instruction
//  trap_valid    out  1   1-cycle pulse: access fault retired as trap
//  trap_mcause   out  32  5 = load access fault, 7 = store/AMO access fault
//  trap_mtval    out  32  faulting address; RST_PC_MTVAL when idle
//  minstret      out  64  retired-instruction count
//  perf_ld_cnt   out  32  retired loads (0 unless WBU_PERF_CNT_EN)
//  perf_st_cnt   out  32  retired stores (0 unless WBU_PERF_CNT_EN)
//  perf_flt_cnt  out  32  access faults (0 unless WBU_PERF_CNT_EN)
// BEHAVIOUR
//  Reset: state=IDLE, wbu_ready=1, every other output 0, trap_mtval=RST_PC_MTVAL, minstret=0.
//  FSM IDLE: wbu_ready=1. On lsu_valid&wbu_ready, latch both buses and access_fault; go to COMMIT.
//  FSM COMMIT (exactly one cycle): wbu_ready=0; wbu_valid=1, commit_pc=latched pc; then IDLE.
//  Latency: handshake edge N -> rf_we/wbu_valid high during cycle N+1. Throughput: 1 per 2 cycles.
//  rf_we=1 in COMMIT iff latched rf_we & rd!=0 & !fault. rd==0 never writes.
//  rf_wdata, non-load: result_or_addr. Load: off=addr[1:0]; lane = rdata >> (off*8).
//    rop 001 byte: sext/zext(lane[7:0]); 010 half: sext/zext(lane[15:0]); 100 or other: rdata.
//    load_uns selects zero-extension.
//  Misaligned half at off=3 is not checked here; it yields lane[15:0] with undefined upper byte.
//  Fault: trap_valid=1 in COMMIT, mcause 5 if is_load else 7, mtval=address; rf_we=0;
//    wbu_valid still 1, so the IFU proceeds to the trap vector; minstret not incremented.
//  minstret += 1 at the COMMIT edge when there is no fault; wraps at 2^64 silently.
//  Pulses (rf_we, wbu_valid, trap_valid) deassert in the cycle after COMMIT.
//    rf_waddr/rf_wdata/commit_pc hold their values until the next commit.
//  lsu_valid while in COMMIT is ignored (wbu_ready=0). The LSU holds until the next IDLE cycle.
//  Reset asserted in COMMIT: the instruction is dropped (no write, no count) and all outputs
//    return to reset values.
// CONFIGURATION
//  `define WBU_PERF_CNT_EN: three 32-bit wrap-around counters, incremented in COMMIT.
//    ld: is_load & !fault. st: is_store & !fault. flt: fault.
//  Without the macro the perf_* ports exist, are tied to 0, and no counter flops are built.
// STRUCTURE
//  ysyx_25020037_config.vh holds:
//    DU_TO_WU_BUS_WD=44, LU_TO_WU_BUS_WD=64, field bit offsets,
//    the rop encodings (001/010/100), and MCAUSE_LD_FAULT=5, MCAUSE_ST_FAULT=7.
//  Sub-module ysyx_25020037_load_ext: combinational (rdata, off, rop, uns) -> 32-bit value.
//  The FSM, latches and counters stay in the WBU.
// TESTING
//  ALU op: result=0x1234_5678, rd=5, rf_we=1
//    -> cycle N+1: rf_we=1, waddr=5, wdata=0x12345678, wbu_valid=1; minstret 0->1.
//  lb: addr=0x8000_0003, rdata=0x80AA_BBCC, uns=0 -> wdata=0xFFFF_FF80.
//    lbu at the same address -> 0x0000_0080.
//  lh: addr off=2, rdata=0x7FFF_0000 -> wdata=0x0000_7FFF.
//    lhu at off=0, rdata=0x0000_8001 -> 0x0000_8001.
//  Load fault: access_fault=1, addr=0x1000_0000, rd=3 -> rf_we=0, trap_valid=1, mcause=5,
//    mtval=0x1000_0000, wbu_valid=1, minstret unchanged.
//  rd=0 write; then back-to-back lsu_valid held high -> no rf_we;
//    second accept only after wbu_ready returns (2-cycle spacing).
//  rst_n low during COMMIT -> rf_we/wbu_valid drop immediately, minstret=0.
//    With WBU_PERF_CNT_EN, 3 loads + 1 store -> ld=3, st=1.

Source files
------------

// File: rtl/ysyx_25020037_wbu_pkg.sv
// rtl/ysyx_25020037_wbu_pkg.sv - write-back stage bus layouts, encodings and FSM states
// Shared by the WBU top, its handshake interface and the load extender.
package ysyx_25020037_wbu_pkg;

  localparam int DU_TO_WU_BUS_WD = 44;
  localparam int LU_TO_WU_BUS_WD = 64;

  localparam logic [2:0] ROP_BYTE = 3'b001;
  localparam logic [2:0] ROP_HALF = 3'b010;
  localparam logic [2:0] ROP_WORD = 3'b100;

  localparam logic [31:0] MCAUSE_LD_FAULT = 32'd5;
  localparam logic [31:0] MCAUSE_ST_FAULT = 32'd7;

  // Member order fixes the bit offsets of the incoming buses (first member = MSBs).
  typedef struct packed {
    logic [31:0] pc;
    logic        is_store;
    logic        is_load;
    logic        load_uns;
    logic [2:0]  rop;
    logic        rf_we;
    logic [4:0]  rd;
  } du_bus_t;

  typedef struct packed {
    logic [31:0] result_or_addr;
    logic [31:0] rdata;
  } lu_bus_t;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_COMMIT = 1'b1
  } wbu_state_e;

endpackage

// File: rtl/ysyx_25020037_wbu_if.sv
// rtl/ysyx_25020037_wbu_if.sv - LSU to WBU handover handshake and result buses
// master = LSU side, slave = WBU side.
interface ysyx_25020037_wbu_if;
  import ysyx_25020037_wbu_pkg::*;

  logic                       lsu_valid;
  logic                       wbu_ready;
  logic [LU_TO_WU_BUS_WD-1:0] lu_to_wu_bus;
  logic [DU_TO_WU_BUS_WD-1:0] du_to_wu_bus;
  logic                       access_fault;

  modport master (
    output lsu_valid, lu_to_wu_bus, du_to_wu_bus, access_fault,
    input  wbu_ready
  );

  modport slave (
    input  lsu_valid, lu_to_wu_bus, du_to_wu_bus, access_fault,
    output wbu_ready
  );

endinterface

// File: rtl/ysyx_25020037_load_ext.sv
// rtl/ysyx_25020037_load_ext.sv - combinational load lane select and sign/zero extension
// A half at offset 3 sees zeros shifted into the upper byte; callers must not rely on it.
module ysyx_25020037_load_ext
  import ysyx_25020037_wbu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_rop,
  input  logic        i_uns,
  output logic [31:0] o_data
);

  logic [15:0] w_lane;

  assign w_lane = 16'(i_rdata >> {i_off, 3'b000});

  always_comb begin
    o_data = i_rdata;
    case (i_rop)
      ROP_BYTE: o_data = i_uns ? {24'd0, w_lane[7:0]}  : {{24{w_lane[7]}}, w_lane[7:0]};
      ROP_HALF: o_data = i_uns ? {16'd0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
      default:  o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_25020037_wbu.sv
// rtl/ysyx_25020037_wbu.sv - write-back stage: regfile write, commit, fault-to-trap, minstret
// Optional retire/fault performance counters under `define WBU_PERF_CNT_EN.
module ysyx_25020037_wbu
  import ysyx_25020037_wbu_pkg::*;
#(
  parameter logic [31:0] RST_PC_MTVAL = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ysyx_25020037_wbu_if.slave    lsu,
  output logic                  o_rf_we,
  output logic [4:0]            o_rf_waddr,
  output logic [31:0]           o_rf_wdata,
  output logic                  o_wbu_valid,
  output logic [31:0]           o_commit_pc,
  output logic                  o_trap_valid,
  output logic [31:0]           o_trap_mcause,
  output logic [31:0]           o_trap_mtval,
  output logic [63:0]           o_minstret,
  output logic [31:0]           o_perf_ld_cnt,
  output logic [31:0]           o_perf_st_cnt,
  output logic [31:0]           o_perf_flt_cnt
);

  wbu_state_e  r_state;
  wbu_state_e  w_next;
  du_bus_t     r_du;
  lu_bus_t     r_lu;
  logic        r_fault;
  logic [63:0] r_minstret;
  logic        w_accept;
  logic [31:0] w_ld_data;

  assign w_accept = lsu.lsu_valid & lsu.wbu_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_du       <= '0;
      r_lu       <= '0;
      r_fault    <= 1'b0;
      r_minstret <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_du    <= lsu.du_to_wu_bus;
        r_lu    <= lsu.lu_to_wu_bus;
        r_fault <= lsu.access_fault;
      end
      if (r_state == S_COMMIT && !r_fault)
        r_minstret <= r_minstret + 64'd1;
    end
  end

  always_comb begin
    w_next        = r_state;
    lsu.wbu_ready = 1'b0;
    o_wbu_valid   = 1'b0;
    o_rf_we       = 1'b0;
    o_trap_valid  = 1'b0;
    o_trap_mcause = '0;
    o_trap_mtval  = RST_PC_MTVAL;
    case (r_state)
      S_IDLE: begin
        lsu.wbu_ready = 1'b1;
        if (lsu.lsu_valid)
          w_next = S_COMMIT;
      end
      S_COMMIT: begin
        o_wbu_valid  = 1'b1;
        o_rf_we      = r_du.rf_we & (r_du.rd != 5'd0) & ~r_fault;
        o_trap_valid = r_fault;
        if (r_fault) begin
          o_trap_mcause = r_du.is_load ? MCAUSE_LD_FAULT : MCAUSE_ST_FAULT;
          o_trap_mtval  = r_lu.result_or_addr;
        end
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  ysyx_25020037_load_ext u_load_ext (
    .i_rdata (r_lu.rdata),
    .i_off   (r_lu.result_or_addr[1:0]),
    .i_rop   (r_du.rop),
    .i_uns   (r_du.load_uns),
    .o_data  (w_ld_data)
  );

  // Latched fields only change on acceptance, so these hold until the next commit.
  assign o_rf_waddr  = r_du.rd;
  assign o_rf_wdata  = r_du.is_load ? w_ld_data : r_lu.result_or_addr;
  assign o_commit_pc = r_du.pc;
  assign o_minstret  = r_minstret;

`ifdef WBU_PERF_CNT_EN
  logic [31:0] r_ld_cnt;
  logic [31:0] r_st_cnt;
  logic [31:0] r_flt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_cnt  <= '0;
      r_st_cnt  <= '0;
      r_flt_cnt <= '0;
    end else if (r_state == S_COMMIT) begin
      if (r_du.is_load && !r_fault)
        r_ld_cnt <= r_ld_cnt + 32'd1;
      if (r_du.is_store && !r_fault)
        r_st_cnt <= r_st_cnt + 32'd1;
      if (r_fault)
        r_flt_cnt <= r_flt_cnt + 32'd1;
    end
  end

  assign o_perf_ld_cnt  = r_ld_cnt;
  assign o_perf_st_cnt  = r_st_cnt;
  assign o_perf_flt_cnt = r_flt_cnt;
`else
  logic w_unused_is_store;

  assign w_unused_is_store = r_du.is_store;
  assign o_perf_ld_cnt     = '0;
  assign o_perf_st_cnt     = '0;
  assign o_perf_flt_cnt    = '0;
`endif

endmodule

// File: tb/tb_ysyx_25020037_wbu.sv
// tb/tb_ysyx_25020037_wbu.sv - self-checking bench for the write-back stage
module tb_ysyx_25020037_wbu;

  localparam logic [31:0] RST_MTVAL = 32'h0000_0F00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rf_we, wbu_valid, trap_valid;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, commit_pc, trap_mcause, trap_mtval;
  logic [63:0] minstret;
  logic [31:0] perf_ld, perf_st, perf_flt;

  ysyx_25020037_wbu_if bus();

  ysyx_25020037_wbu #(.RST_PC_MTVAL(RST_MTVAL)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lsu            (bus),
    .o_rf_we        (rf_we),
    .o_rf_waddr     (rf_waddr),
    .o_rf_wdata     (rf_wdata),
    .o_wbu_valid    (wbu_valid),
    .o_commit_pc    (commit_pc),
    .o_trap_valid   (trap_valid),
    .o_trap_mcause  (trap_mcause),
    .o_trap_mtval   (trap_mtval),
    .o_minstret     (minstret),
    .o_perf_ld_cnt  (perf_ld),
    .o_perf_st_cnt  (perf_st),
    .o_perf_flt_cnt (perf_flt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        st, ld, uns;
    logic [2:0]  rop;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] res, rdata;
    logic        flt;
    logic [31:0] e_wdata;
    logic        e_we, e_trap;
    logic [31:0] e_mcause, e_mtval;
  } vec_t;

  int checks = 0;
  int errors = 0;
  longint unsigned m_minstret = 0;
  int unsigned m_ld = 0, m_st = 0, m_flt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference load extension from plain arithmetic on the addressed bytes.
  function automatic logic [31:0] ref_wdata(input logic ld, input logic uns, input logic [2:0] rop,
                                            input logic [31:0] addr, input logic [31:0] rdata,
                                            input logic [31:0] res);
    longint unsigned lane, v;
    int unsigned off;
    if (!ld) return res;
    off  = int'(addr % 4);
    lane = longint'(rdata) / (64'd1 << (8 * off));
    if (rop == 3'd1) begin
      v = lane % 256;
      if (!uns && v >= 128) v = v + 64'hFFFF_FF00;
      return v[31:0];
    end
    if (rop == 3'd2) begin
      v = lane % 65536;
      if (!uns && v >= 32768) v = v + 64'hFFFF_0000;
      return v[31:0];
    end
    return rdata;
  endfunction

  function automatic vec_t expect_of(input vec_t v);
    vec_t r = v;
    r.e_we     = v.we && v.rd != 5'd0 && !v.flt;
    r.e_trap   = v.flt;
    r.e_mcause = v.flt ? (v.ld ? 32'd5 : 32'd7) : 32'd0;
    r.e_mtval  = v.flt ? v.res : RST_MTVAL;
    r.e_wdata  = ref_wdata(v.ld, v.uns, v.rop, v.res, v.rdata, v.res);
    return r;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!bus.wbu_ready && n < 4) begin
      @(negedge clk);
      n++;
    end
    if (!bus.wbu_ready) chk("ready_timeout", 64'(bus.wbu_ready), 64'd1);
  endtask

  // Called at a negedge; returns at the negedge of the cycle after COMMIT.
  task automatic apply_vec(input string tag, input vec_t v);
    wait_ready();
    bus.du_to_wu_bus = {v.pc, v.st, v.ld, v.uns, v.rop, v.we, v.rd};
    bus.lu_to_wu_bus = {v.res, v.rdata};
    bus.access_fault = v.flt;
    bus.lsu_valid    = 1'b1;
    @(posedge clk);
    #1 bus.lsu_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".wbu_valid"}, 64'(wbu_valid), 64'd1);
    chk({tag, ".ready_low"}, 64'(bus.wbu_ready), 64'd0);
    chk({tag, ".rf_we"}, 64'(rf_we), 64'(v.e_we));
    chk({tag, ".waddr"}, 64'(rf_waddr), 64'(v.rd));
    if (!v.flt) chk({tag, ".wdata"}, 64'(rf_wdata), 64'(v.e_wdata));
    chk({tag, ".pc"}, 64'(commit_pc), 64'(v.pc));
    chk({tag, ".trap"}, 64'(trap_valid), 64'(v.e_trap));
    chk({tag, ".mcause"}, 64'(trap_mcause), 64'(v.e_mcause));
    chk({tag, ".mtval"}, 64'(trap_mtval), 64'(v.e_mtval));
    if (!v.flt) m_minstret++;
    if (v.ld && !v.flt) m_ld++;
    if (v.st && !v.flt) m_st++;
    if (v.flt) m_flt++;
    @(negedge clk);
    chk({tag, ".minstret"}, minstret, m_minstret);
    chk({tag, ".pulses_off"}, 64'({rf_we, wbu_valid, trap_valid}), 64'd0);
    chk({tag, ".mtval_idle"}, 64'(trap_mtval), 64'(RST_MTVAL));
    chk({tag, ".pc_hold"}, 64'(commit_pc), 64'(v.pc));
    if (!v.flt) chk({tag, ".wdata_hold"}, 64'(rf_wdata), 64'(v.e_wdata));
  endtask

  task automatic chk_perf(input string tag);
`ifdef WBU_PERF_CNT_EN
    chk({tag, ".perf_ld"}, 64'(perf_ld), 64'(m_ld));
    chk({tag, ".perf_st"}, 64'(perf_st), 64'(m_st));
    chk({tag, ".perf_flt"}, 64'(perf_flt), 64'(m_flt));
`else
    chk({tag, ".perf_zero"}, 64'({perf_ld, perf_st, perf_flt}), 64'd0);
`endif
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".ready"}, 64'(bus.wbu_ready), 64'd1);
    chk({tag, ".pulses"}, 64'({rf_we, wbu_valid, trap_valid}), 64'd0);
    chk({tag, ".waddr"}, 64'(rf_waddr), 64'd0);
    chk({tag, ".wdata"}, 64'(rf_wdata), 64'd0);
    chk({tag, ".pc"}, 64'(commit_pc), 64'd0);
    chk({tag, ".mcause"}, 64'(trap_mcause), 64'd0);
    chk({tag, ".mtval"}, 64'(trap_mtval), 64'(RST_MTVAL));
    chk({tag, ".minstret"}, minstret, 64'd0);
    chk_perf(tag);
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    int accepts, commits, we_seen, overlap;
    logic [31:0] rnd;

    bus.lsu_valid = 1'b0;
    bus.du_to_wu_bus = '0;
    bus.lu_to_wu_bus = '0;
    bus.access_fault = 1'b0;

    // {pc, st, ld, uns, rop, we, rd, res, rdata, flt, e_wdata, e_we, e_trap, e_mcause, e_mtval}
    tbl.push_back('{32'h8000_0000, 0, 0, 0, 3'b000, 1, 5'd5,  32'h1234_5678, 32'h0,         0, 32'h1234_5678, 1, 0, 32'd0, RST_MTVAL});
    tbl.push_back('{32'h8000_0004, 0, 1, 0, 3'b001, 1, 5'd6,  32'h8000_0003, 32'h80AA_BBCC, 0, 32'hFFFF_FF80, 1, 0, 32'd0, RST_MTVAL});
    tbl.push_back('{32'h8000_0008, 0, 1, 1, 3'b001, 1, 5'd7,  32'h8000_0003, 32'h80AA_BBCC, 0, 32'h0000_0080, 1, 0, 32'd0, RST_MTVAL});
    tbl.push_back('{32'h8000_000C, 0, 1, 0, 3'b010, 1, 5'd8,  32'h8000_0102, 32'h7FFF_0000, 0, 32'h0000_7FFF, 1, 0, 32'd0, RST_MTVAL});
    tbl.push_back('{32'h8000_0010, 0, 1, 1, 3'b010, 1, 5'd9,  32'h8000_0100, 32'h0000_8001, 0, 32'h0000_8001, 1, 0, 32'd0, RST_MTVAL});
    tbl.push_back('{32'h8000_0014, 0, 1, 0, 3'b010, 1, 5'd10, 32'h8000_0100, 32'h1234_8001, 0, 32'hFFFF_8001, 1, 0, 32'd0, RST_MTVAL});
    tbl.push_back('{32'h8000_0018, 0, 1, 0, 3'b100, 1, 5'd11, 32'h8000_0200, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1, 0, 32'd0, RST_MTVAL});
    tbl.push_back('{32'h8000_001C, 0, 1, 0, 3'b011, 1, 5'd12, 32'h8000_0201, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1, 0, 32'd0, RST_MTVAL});
    tbl.push_back('{32'h8000_0020, 0, 1, 0, 3'b100, 1, 5'd3,  32'h1000_0000, 32'h5555_5555, 1, 32'h0,         0, 1, 32'd5, 32'h1000_0000});
    tbl.push_back('{32'h8000_0024, 1, 0, 0, 3'b100, 0, 5'd0,  32'h2000_0004, 32'h0,         1, 32'h0,         0, 1, 32'd7, 32'h2000_0004});
    tbl.push_back('{32'h8000_0028, 1, 0, 0, 3'b100, 0, 5'd0,  32'h2000_0008, 32'h0,         0, 32'h2000_0008, 0, 0, 32'd0, RST_MTVAL});
    tbl.push_back('{32'h8000_002C, 0, 0, 0, 3'b000, 1, 5'd0,  32'hFFFF_FFFF, 32'h0,         0, 32'hFFFF_FFFF, 0, 0, 32'd0, RST_MTVAL});

    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_state("post_reset");

    foreach (tbl[i]) apply_vec($sformatf("tbl%0d", i), tbl[i]);
    chk_perf("tbl");

    // Held lsu_valid with rd=0: accepts every other cycle, never writes.
    wait_ready();
    bus.du_to_wu_bus = {32'h8000_0100, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd0};
    bus.lu_to_wu_bus = {32'h0BAD_0BAD, 32'h0};
    bus.access_fault = 1'b0;
    bus.lsu_valid    = 1'b1;
    accepts = 0; commits = 0; we_seen = 0; overlap = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.wbu_ready) accepts++;
      if (wbu_valid) commits++;
      if (rf_we) we_seen++;
      if (wbu_valid && bus.wbu_ready) overlap++;
      @(negedge clk);
    end
    bus.lsu_valid = 1'b0;
    m_minstret += 4;
    chk("b2b.accepts", 64'(accepts), 64'd4);
    chk("b2b.commits", 64'(commits), 64'd4);
    chk("b2b.no_we", 64'(we_seen), 64'd0);
    chk("b2b.ready_in_commit", 64'(overlap), 64'd0);
    @(negedge clk);
    chk("b2b.minstret", minstret, m_minstret);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 60; i++) begin
      int kind;
      rnd    = $urandom;
      kind   = int'($urandom_range(0, 2));
      v.pc   = rnd & 32'hFFFF_FFFC;
      v.ld   = (kind == 1);
      v.st   = (kind == 2);
      v.uns  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: v.rop = 3'b001;
        1: v.rop = 3'b010;
        2: v.rop = 3'b100;
        default: v.rop = 3'b011;
      endcase
      v.res   = $urandom;
      if (v.ld && v.rop == 3'b010 && v.res[1:0] == 2'd3) v.res[1:0] = 2'd2;
      v.rdata = $urandom;
      v.we    = v.st ? 1'b0 : ($urandom_range(0, 7) != 0);
      v.rd    = 5'($urandom_range(0, 31));
      v.flt   = (!(kind == 0)) && ($urandom_range(0, 5) == 0);
      apply_vec($sformatf("rnd%0d", i), expect_of(v));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    chk_perf("rnd");

    // Reset during COMMIT drops the instruction and clears everything at once.
    v = expect_of('{32'h8000_0200, 0, 1, 0, 3'b100, 1, 5'd4, 32'h8000_0000, 32'h1111_2222,
                    0, 32'h0, 0, 0, 32'd0, 32'h0});
    wait_ready();
    bus.du_to_wu_bus = {v.pc, v.st, v.ld, v.uns, v.rop, v.we, v.rd};
    bus.lu_to_wu_bus = {v.res, v.rdata};
    bus.access_fault = 1'b0;
    bus.lsu_valid    = 1'b1;
    @(posedge clk);
    #1 bus.lsu_valid = 1'b0;
    @(negedge clk);
    chk("rstc.in_commit", 64'({wbu_valid, rf_we}), 64'b11);
    rst_n = 1'b0;
    #1;
    m_minstret = 0; m_ld = 0; m_st = 0; m_flt = 0;
    chk_reset_state("rstc");
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rstc.minstret_kept0", minstret, 64'd0);

    // Three loads and a store after reset for the optional counters.
    for (int i = 0; i < 4; i++) begin
      v = expect_of('{32'h8000_0300 + 32'(i * 4), (i == 3), (i != 3), 0, 3'b100, (i != 3),
                      5'(i + 1), 32'h8000_1000, 32'(i), 0, 32'h0, 0, 0, 32'd0, 32'h0});
      apply_vec($sformatf("perf%0d", i), v);
    end
    chk_perf("perf");
    chk("perf.minstret", minstret, 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
